// File: rtl/pio_avmm_arbiter.sv
// pio_avmm_arbiter
//   Round-robin arbiter that shares one Avalon-MM PIO slave between NUM_REQ
//   requesters. It serialises single-beat reads and writes onto one master port
//   and returns read data to the requester that issued the read.
//   Transaction flow: IDLE -> ISSUE -> IDLE (write)
//                     IDLE -> ISSUE -> WAIT_RD -> RESP -> IDLE (read)
//   Optional feature macro: PIO_ARB_LOCK_EN adds the req_lock port and the
//   LOCK_MAX parameter, so one owner can keep the bus for several transactions
//   (for example, a read-modify-write of the direction and data registers).
module pio_avmm_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 3,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
`ifdef PIO_ARB_LOCK_EN
    ,
    parameter int LOCK_MAX     = 4
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_address,
    input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
`ifdef PIO_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]        req_lock,
`endif
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_readdata,
    output logic [ADDR_W-1:0]         m_address,
    output logic                      m_write,
    output logic                      m_read,
    output logic [DATA_W-1:0]         m_writedata,
    input  logic [DATA_W-1:0]         m_readdata
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT_RD = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    logic [1:0]             state;
    logic [PTR_W-1:0]       rr_ptr;
    logic [PTR_W-1:0]       owner;
    logic [CNT_W-1:0]       wait_cnt;

    // Round-robin search results and the payload of the selected requester
    logic [2*NUM_REQ-1:0]   valid_dbl;
    logic [NUM_REQ-1:0]     rot_valid;
    logic                   grant_found;
    logic [PTR_W:0]         idx_sum;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       sel_idx;
    logic                   sel_write;
    logic [ADDR_W-1:0]      sel_addr;
    logic [DATA_W-1:0]      sel_wdata;
    logic [PTR_W-1:0]       next_ptr;

`ifdef PIO_ARB_LOCK_EN
    localparam int LCNT_W = $clog2(LOCK_MAX + 1);

    logic [LCNT_W-1:0]      lock_cnt;
    logic                   owner_valid;
    logic                   lock_hit;
`endif

    // Find the first valid requester at or after rr_ptr. The request vector is
    // doubled and shifted so the search starts at offset 0 of rot_valid, then
    // the offset is added back to rr_ptr modulo NUM_REQ.
    always_comb begin
        valid_dbl   = {req_valid, req_valid} >> rr_ptr;
        rot_valid   = valid_dbl[NUM_REQ-1:0];
        grant_found = 1'b0;
        idx_sum     = '0;
        grant_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && rot_valid[k]) begin
                grant_found = 1'b1;
                idx_sum     = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            end
        end
        if (idx_sum >= (PTR_W+1)'(NUM_REQ)) begin
            grant_idx = PTR_W'(idx_sum - (PTR_W+1)'(NUM_REQ));
        end else begin
            grant_idx = idx_sum[PTR_W-1:0];
        end
    end

`ifdef PIO_ARB_LOCK_EN
    // A locked owner that still requests keeps the bus until it has had
    // LOCK_MAX consecutive re-grants; otherwise normal rotation takes over.
    always_comb begin
        lock_hit = owner_valid && req_lock[owner] && req_valid[owner] &&
                   (lock_cnt < LCNT_W'(LOCK_MAX));
        sel_idx  = lock_hit ? owner : grant_idx;
    end
`else
    // Without locking, the round-robin winner is always the selected requester
    always_comb begin
        sel_idx = grant_idx;
    end
`endif

    // Pick the selected requester's write flag, address and write data out of the packed buses
    always_comb begin
        sel_write = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel_idx == PTR_W'(i)) begin
                sel_write = req_write[i];
                sel_addr  = req_address[i*ADDR_W +: ADDR_W];
                sel_wdata = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    // The pointer moves to the requester after the one just served, wrapping at NUM_REQ
    always_comb begin
        if (owner == PTR_W'(NUM_REQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = owner + 1'b1;
        end
    end

    // Transaction FSM. Every output is a register, loaded at the edge that
    // enters the state in which it must be visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            wait_cnt     <= '0;
            req_ready    <= '0;
            rsp_valid    <= '0;
            rsp_readdata <= '0;
            m_address    <= '0;
            m_write      <= 1'b0;
            m_read       <= 1'b0;
            m_writedata  <= '0;
`ifdef PIO_ARB_LOCK_EN
            lock_cnt     <= '0;
            owner_valid  <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|req_valid) begin
                        state       <= ST_ISSUE;
                        owner       <= sel_idx;
                        m_address   <= sel_addr;
                        m_writedata <= sel_wdata;
                        m_write     <= sel_write;
                        m_read      <= ~sel_write;
                        req_ready   <= NUM_REQ'(1) << sel_idx;
`ifdef PIO_ARB_LOCK_EN
                        if (lock_hit) begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end else begin
                            lock_cnt <= '0;
                        end
`endif
                    end
                end
                ST_ISSUE: begin
                    m_write   <= 1'b0;
                    m_read    <= 1'b0;
                    req_ready <= '0;
                    rr_ptr    <= next_ptr;
                    wait_cnt  <= '0;
`ifdef PIO_ARB_LOCK_EN
                    owner_valid <= 1'b1;
`endif
                    if (m_write) begin
                        state <= ST_IDLE;
                    end else begin
                        state <= ST_WAIT_RD;
                    end
                end
                ST_WAIT_RD: begin
                    if (wait_cnt == CNT_W'(READ_LATENCY - 1)) begin
                        rsp_readdata <= m_readdata;
                        rsp_valid    <= NUM_REQ'(1) << owner;
                        state        <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    rsp_valid <= '0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pio_avmm_arbiter.sv
// tb_pio_avmm_arbiter
//   Directed bench for pio_avmm_arbiter (default parameters). Inputs are
//   driven and outputs are sampled just after each falling clock edge.
//   Define PIO_ARB_LOCK_EN to connect req_lock and run the lock scenario.
module tb_pio_avmm_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 3;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_address;
    logic [NUM_REQ*DATA_W-1:0] req_writedata;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_readdata;
    logic [ADDR_W-1:0]         m_address;
    logic                      m_write;
    logic                      m_read;
    logic [DATA_W-1:0]         m_writedata;
    logic [DATA_W-1:0]         m_readdata;

    int n_compared;
    int n_mismatched;

    pio_avmm_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_write     (req_write),
        .req_address   (req_address),
        .req_writedata (req_writedata),
`ifdef PIO_ARB_LOCK_EN
        .req_lock      (req_lock),
`endif
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_readdata  (rsp_readdata),
        .m_address     (m_address),
        .m_write       (m_write),
        .m_read        (m_read),
        .m_writedata   (m_writedata),
        .m_readdata    (m_readdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Default payload: every requester writes, requester i uses address 4+i and data 0xA0+i
    task automatic load_payloads();
        req_write     = '1;
        req_address   = {3'd7, 3'd6, 3'd5, 3'd4};
        req_writedata = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    endtask

    task automatic set_req(input int i, input logic wr, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] data);
        req_write[i]                      = wr;
        req_address[i*ADDR_W +: ADDR_W]   = addr;
        req_writedata[i*DATA_W +: DATA_W] = data;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_lock  = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [2*NUM_REQ+2*ADDR_W+2*DATA_W-ADDR_W+1:0] all_out;
        reset      = 1'b1;
        req_lock   = '0;
        m_readdata = 32'h0;
        load_payloads();
        req_valid = 4'hF;
        repeat (3) begin
            @(negedge clk);
            all_out = {m_write, m_read, req_ready, rsp_valid, m_address, m_writedata, rsp_readdata};
            n_compared++;
            if (all_out !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_outputs: got %h expected 0", all_out);
            end
        end
        reset = 1'b0;
        @(negedge clk);
        n_compared++;
        if (req_ready !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL reset_first_grant: got %b expected 0001", req_ready);
        end
        n_compared++;
        if ({m_write, m_read, m_address, m_writedata} !== {1'b1, 1'b0, 3'd4, 32'hA0}) begin
            n_mismatched++;
            $display("[TB] FAIL reset_first_issue: got w=%b r=%b a=%h d=%h expected w=1 r=0 a=4 d=a0",
                     m_write, m_read, m_address, m_writedata);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_single_write();
        do_reset();
        load_payloads();
        set_req(2, 1'b1, 3'b001, 32'h1);
        req_valid = 4'b0100;
        @(negedge clk);
        n_compared++;
        if ({m_write, m_read, m_address, m_writedata, req_ready} !== {1'b1, 1'b0, 3'd1, 32'h1, 4'b0100}) begin
            n_mismatched++;
            $display("[TB] FAIL write_issue: got w=%b r=%b a=%h d=%h rdy=%b expected w=1 r=0 a=1 d=1 rdy=0100",
                     m_write, m_read, m_address, m_writedata, req_ready);
        end
        req_valid = '0;
        @(negedge clk);
        n_compared++;
        if ({m_write, m_read, req_ready} !== 6'b0) begin
            n_mismatched++;
            $display("[TB] FAIL write_one_cycle: got w=%b r=%b rdy=%b expected all 0", m_write, m_read, req_ready);
        end
        n_compared++;
        if ({m_address, m_writedata} !== {3'd1, 32'h1}) begin
            n_mismatched++;
            $display("[TB] FAIL write_hold: got a=%h d=%h expected a=1 d=1", m_address, m_writedata);
        end
    endtask

    // rr_ptr is 3 after the req2 write; idle cycles must not move it
    task automatic test_idle_hold();
        req_valid = '0;
        repeat (4) begin
            @(negedge clk);
            n_compared++;
            if ({m_write, m_read, req_ready, rsp_valid} !== 10'b0) begin
                n_mismatched++;
                $display("[TB] FAIL idle_quiet: got w=%b r=%b rdy=%b rsp=%b expected all 0",
                         m_write, m_read, req_ready, rsp_valid);
            end
        end
        load_payloads();
        req_valid = 4'hF;
        @(negedge clk);
        n_compared++;
        if ({req_ready, m_address} !== {4'b1000, 3'd7}) begin
            n_mismatched++;
            $display("[TB] FAIL idle_ptr_kept: got rdy=%b a=%h expected rdy=1000 a=7", req_ready, m_address);
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [NUM_REQ-1:0] exp_ready [9];
        logic [ADDR_W-1:0]  exp_addr  [9];
        exp_ready = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        exp_addr  = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd7, 3'd7, 3'd4};
        do_reset();
        load_payloads();
        req_valid = 4'hF;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            n_compared++;
            if ({req_ready, m_write, m_read} !== {exp_ready[k], (exp_ready[k] != 4'b0), 1'b0}) begin
                n_mismatched++;
                $display("[TB] FAIL rr_cycle%0d: got rdy=%b w=%b r=%b expected rdy=%b", k,
                         req_ready, m_write, m_read, exp_ready[k]);
            end
            n_compared++;
            if (m_address !== exp_addr[k]) begin
                n_mismatched++;
                $display("[TB] FAIL rr_addr%0d: got %h expected %h", k, m_address, exp_addr[k]);
            end
        end
        req_valid = '0;
        @(negedge clk);
    endtask

    // Requester 1 reads address 1; the slave data is only valid in the cycle after m_read
    task automatic test_read(input logic [DATA_W-1:0] val);
        set_req(1, 1'b0, 3'b001, 32'h0);
        req_valid  = 4'b0010;
        m_readdata = 32'hDEADBEEF;
        @(negedge clk);
        n_compared++;
        if ({m_read, m_write, req_ready, m_address} !== {1'b1, 1'b0, 4'b0010, 3'd1}) begin
            n_mismatched++;
            $display("[TB] FAIL read_issue: got r=%b w=%b rdy=%b a=%h expected r=1 w=0 rdy=0010 a=1",
                     m_read, m_write, req_ready, m_address);
        end
        req_valid = '0;
        @(negedge clk);
        m_readdata = val;
        n_compared++;
        if ({m_read, rsp_valid} !== 5'b0) begin
            n_mismatched++;
            $display("[TB] FAIL read_wait: got r=%b rsp=%b expected 0", m_read, rsp_valid);
        end
        @(negedge clk);
        m_readdata = 32'hDEADBEEF;
        n_compared++;
        if ({rsp_valid, rsp_readdata} !== {4'b0010, val}) begin
            n_mismatched++;
            $display("[TB] FAIL read_resp: got rsp=%b data=%h expected rsp=0010 data=%h",
                     rsp_valid, rsp_readdata, val);
        end
        @(negedge clk);
        n_compared++;
        if (rsp_valid !== 4'b0) begin
            n_mismatched++;
            $display("[TB] FAIL read_resp_pulse: got %b expected 0000", rsp_valid);
        end
    endtask

    // Reset while waiting for read data; the previous owner was 1 so rr_ptr was 2 before reset
    task automatic test_reset_mid_read();
        set_req(1, 1'b0, 3'b010, 32'h0);
        req_valid  = 4'b0010;
        m_readdata = 32'h5A5A5A5A;
        @(negedge clk);
        n_compared++;
        if (m_read !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL midrd_issue: got r=%b expected 1", m_read);
        end
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_compared++;
            if ({rsp_valid, rsp_readdata, m_read, m_write, req_ready} !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL midrd_abandon: got rsp=%b data=%h r=%b w=%b rdy=%b expected all 0",
                         rsp_valid, rsp_readdata, m_read, m_write, req_ready);
            end
        end
        reset = 1'b0;
        load_payloads();
        req_valid = 4'hF;
        @(negedge clk);
        n_compared++;
        if (req_ready !== 4'b0001) begin
            n_mismatched++;
            $display("[TB] FAIL midrd_ptr_cleared: got %b expected 0001", req_ready);
        end
        req_valid  = '0;
        m_readdata = 32'h0;
        @(negedge clk);
    endtask

`ifdef PIO_ARB_LOCK_EN
    // Requester 0 locks while 1 also requests: five grants to 0, then 1
    task automatic test_lock();
        logic [NUM_REQ-1:0] exp_ready [11];
        exp_ready = '{4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000,
                      4'b0001, 4'b0000, 4'b0001, 4'b0000, 4'b0010};
        do_reset();
        load_payloads();
        req_lock  = 4'b0001;
        req_valid = 4'b0011;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            n_compared++;
            if (req_ready !== exp_ready[k]) begin
                n_mismatched++;
                $display("[TB] FAIL lock_cycle%0d: got %b expected %b", k, req_ready, exp_ready[k]);
            end
        end
        req_valid = '0;
        req_lock  = '0;
        @(negedge clk);
    endtask
`endif

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset        = 1'b1;
        req_valid    = '0;
        req_lock     = '0;
        m_readdata   = '0;
        load_payloads();
        $display("[TB] starting pio_avmm_arbiter bench");
        test_reset();
        test_single_write();
        test_idle_hold();
        test_round_robin();
        test_read(32'h0);
        test_read(32'h1);
        test_reset_mid_read();
`ifdef PIO_ARB_LOCK_EN
        test_lock();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
